// File: rtl/tea_decryptor_iter.sv
// Iterative TEA block decryptor. It runs one full decryption round per enabled clock,
// 32 rounds per 64-bit block, with valid/ready handshakes on the input and output sides.
module tea_decryptor_iter #(
  parameter logic [31:0] DELTA  = 32'h9E37_79B9,
  parameter int          ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy,
  output logic [1:0]   o_dbg_state
);

  // Handshake rule: a transfer happens on a rising clk edge where valid && ready && ena.
  // Valid must not depend on ready. Data is stable while valid is high and ready is low.
  localparam int                CW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(ROUNDS - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [31:0]       SUM_INIT = 32'(DELTA * 32'(ROUNDS));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_sum;
  logic [31:0]   r_v0;
  logic [31:0]   r_v1;
  logic [127:0]  r_key;
  logic          r_out_valid;
  logic [63:0]   r_out;

  logic [31:0] w_k0;
  logic [31:0] w_k1;
  logic [31:0] w_k2;
  logic [31:0] w_k3;
  logic [31:0] w_v1_next;
  logic [31:0] w_v0_next;
  logic        w_last;

  assign w_k0 = r_key[31:0];
  assign w_k1 = r_key[63:32];
  assign w_k2 = r_key[95:64];
  assign w_k3 = r_key[127:96];

  // v0 is updated from the freshly computed v1. This undoes the encryption order.
  assign w_v1_next = r_v1 - (((r_v0 << 4) + w_k2) ^ (r_v0 + r_sum) ^ ((r_v0 >> 5) + w_k3));
  assign w_v0_next = r_v0 - (((w_v1_next << 4) + w_k0) ^ (w_v1_next + r_sum) ^
                             ((w_v1_next >> 5) + w_k1));
  assign w_last    = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_v0        <= '0;
      r_v1        <= '0;
      r_key       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_v0    <= inBlock64[31:0];
            r_v1    <= inBlock64[63:32];
            r_key   <= key;
            r_sum   <= SUM_INIT;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_v0  <= w_v0_next;
          r_v1  <= w_v1_next;
          r_sum <= r_sum - DELTA;
          if (w_last) begin
            r_cnt       <= '0;
            r_out       <= {w_v1_next, w_v0_next};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign out_valid   = r_out_valid;
  assign outBlock64  = r_out;
  assign o_dbg_state = r_state;

  // After the last round, the sum schedule must have counted back to exactly zero.
  a_sum_zero: assert property (@(posedge clk) disable iff (rst)
    (ena && r_state == S_RUN && w_last) |=> (r_sum == 32'd0));

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_DONE && !(ena && out_ready)) |=> ($stable(r_out) && r_out_valid));

endmodule

// File: tb/tb_tea_decryptor_iter.sv
// Directed bench for tea_decryptor_iter. Ciphertexts come from a reference TEA encryptor,
// and every output is compared against the original plaintext.
module tb_tea_decryptor_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  inBlock64;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  outBlock64;
  logic         busy;
  logic [1:0]   o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [127:0] k;
    logic [63:0]  c;
    logic [63:0]  p;
  } vec_t;
  vec_t tv[6];

  tea_decryptor_iter dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .inBlock64(inBlock64), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .outBlock64(outBlock64),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] v0, v1, s;
    v0 = p[31:0];
    v1 = p[63:32];
    s  = 32'd0;
    for (int r = 0; r < 32; r++) begin
      s  = s + 32'h9E37_79B9;
      v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
      v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
    end
    return {v1, v0};
  endfunction

  // Presents a block on a falling edge and returns the cycle index of the accepting edge.
  task automatic accept_block(input logic [63:0] c, input logic [127:0] k,
                              input bit hold_valid, output int acc_cyc);
    bit hs;
    bit acc;
    acc = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    in_valid  = 1'b1;
    inBlock64 = c;
    key       = k;
    for (int i = 0; i < 200; i++) begin
      hs = in_ready && ena;
      @(posedge clk);
      if (hs) begin
        acc = 1'b1;
        acc_cyc = int'($time / 10);
        break;
      end
      #1;
    end
    #1;
    if (!hold_valid) in_valid = 1'b0;
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Waits for out_valid and scrambles the input bus while the block is in flight.
  task automatic wait_done(output int lat, output int busy_cnt);
    bit got;
    got = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      in_valid  = 1'($urandom_range(0, 1));
      inBlock64 = {$urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    chk("done_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid_ready", {62'd0, out_valid, in_ready}, 64'b01);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready && ena && !rst) begin
      if (exp_q.size() == 0) begin
        chk("stream_unexpected", 64'(out_valid), 64'd0);
      end else begin
        chk("stream_data", outBlock64, exp_q.pop_front());
      end
    end
  end

  initial begin
    int acc, acc_prev, lat, bcnt, ecnt;
    bit got;
    logic [63:0] p, held;
    logic [127:0] k;

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; inBlock64 = '0; key = '0; out_ready = 1'b0;

    tv[0] = '{k: 128'h0, c: 64'h94BAA940_41EA3A0A, p: 64'h0};
    tv[1] = '{k: 128'h0, c: 64'h0, p: 64'h0};
    tv[2] = '{k: 128'h00112233_44556677_8899AABB_CCDDEEFF, c: 64'h0, p: 64'h01234567_89ABCDEF};
    tv[3] = '{k: {128{1'b1}}, c: 64'h0, p: {64{1'b1}}};
    tv[4] = '{k: 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, c: 64'h0, p: 64'h80000000_00000001};
    tv[5] = '{k: 128'h00000001_00000000_80000000_FFFFFFFF, c: 64'h0, p: 64'hA5A5A5A5_5A5A5A5A};
    tv[1].p = 64'h00000001_00000000;
    for (int i = 1; i < 6; i++) tv[i].c = tea_enc(tv[i].p, tv[i].k);

    #12;
    chk("reset_flags", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'b1000);
    chk("reset_block", outBlock64, 64'h0);
    chk("reset_state", 64'(o_dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      out_ready = (i != 0);
      accept_block(tv[i].c, tv[i].k, 1'b0, acc);
      wait_done(lat, bcnt);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd32);
      chk($sformatf("vec%0d_plain", i), outBlock64, tv[i].p);
      chk($sformatf("vec%0d_done_state", i), {61'd0, o_dbg_state, in_ready}, 64'b100);
      if (i == 0) begin
        for (int j = 0; j < 10; j++) begin
          @(posedge clk);
          #1;
          chk("hold_block", outBlock64, tv[0].p);
          chk("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'b10);
        end
      end
      drain();
    end

    // Random ena gaps during RUN must only stretch time, not change the result.
    out_ready = 1'b1;
    accept_block(tv[2].c, tv[2].k, 1'b0, acc);
    ecnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ena = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (ena) ecnt++;
      #1;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    ena = 1'b1;
    chk("ena_done", 64'(got), 64'd1);
    chk("ena_high_cycles", 64'(ecnt), 64'd32);
    chk("ena_plain", outBlock64, tv[2].p);
    drain();

    // Abort at round 15.
    accept_block(tv[4].c, tv[4].k, 1'b0, acc);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
    chk("abort_block", outBlock64, 64'h0);
    chk("abort_state", 64'(o_dbg_state), 64'd0);
    #2;
    rst = 1'b0;
    accept_block(tv[5].c, tv[5].k, 1'b0, acc);
    wait_done(lat, bcnt);
    chk("post_abort_latency", 64'(lat), 64'd32);
    chk("post_abort_plain", outBlock64, tv[5].p);

    // Reset while in DONE drops out_valid at once.
    #2;
    rst = 1'b1;
    #1;
    chk("done_reset_flags", {62'd0, out_valid, in_ready}, 64'b01);
    #1;
    rst = 1'b0;

    // Back-to-back blocks with in_valid held high.
    out_ready = 1'b1;
    mon_en    = 1'b1;
    acc_prev  = -1;
    for (int i = 0; i < 3; i++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      accept_block(tea_enc(p, k), k, 1'b1, acc);
      exp_q.push_back(p);
      if (acc_prev >= 0) chk($sformatf("stream_spacing%0d", i), 64'(acc - acc_prev), 64'd34);
      acc_prev = acc;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("stream_left", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    held = outBlock64;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_block_stable", outBlock64, held);
    chk("idle_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
